// File: rtl/dco_ctrl_pkg.sv
// Shared mode encoding and default sizing for the DCO bank tuning controller.
package dco_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_PVT  = 2'd1,
        MODE_ACQ  = 2'd2,
        MODE_TRK  = 2'd3
    } dco_mode_e;

    localparam int DEF_L_W     = 6;
    localparam int DEF_M_W     = 8;
    localparam int DEF_S_W     = 6;
    localparam int DEF_TW_W    = 16;
    localparam int DEF_FRAC_W  = 4;
    localparam int DEF_LOCK_N  = 8;
    localparam int DEF_THR_PVT = 64;
    localparam int DEF_THR_ACQ = 8;

endpackage

// File: rtl/dco_sd_dither.sv
// First-order sigma-delta on the tuning-word fraction: emits a carry whenever
// the fractional accumulator overflows, so the small bank averages the fraction.
module dco_sd_dither #(
    parameter int FRAC_W = dco_ctrl_pkg::DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, frac};
        carry = sum[FRAC_W];
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dco_tune_ctrl.sv
// Three-bank DCO tuning controller: coarse PVT search, medium acquisition,
// then dithered fine tracking on the small bank.
module dco_tune_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int L_W     = DEF_L_W,
    parameter int M_W     = DEF_M_W,
    parameter int S_W     = DEF_S_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int LOCK_N  = DEF_LOCK_N,
    parameter int THR_PVT = DEF_THR_PVT,
    parameter int THR_ACQ = DEF_THR_ACQ
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [TW_W-1:0] tw,
    input  logic                   tw_valid,
    output logic [L_W-1:0]         dco_in_l,
    output logic [M_W-1:0]         dco_in_m,
    output logic [S_W-1:0]         dco_in_s,
    output logic [1:0]             mode,
    output logic                   sat,
    output logic                   lock
);

    localparam int AW = TW_W + 2;
    localparam int CW = $clog2(LOCK_N + 1);

    localparam logic [L_W-1:0] L_MID = {1'b1, {(L_W-1){1'b0}}};
    localparam logic [M_W-1:0] M_MID = {1'b1, {(M_W-1){1'b0}}};
    localparam logic [S_W-1:0] S_MID = {1'b1, {(S_W-1){1'b0}}};
    localparam logic [L_W-1:0] L_MAX = '1;
    localparam logic [M_W-1:0] M_MAX = '1;
    localparam logic [S_W-1:0] S_MAX = '1;

    localparam logic signed [AW-1:0] THR_PVT_X = AW'(THR_PVT);
    localparam logic signed [AW-1:0] THR_ACQ_X = AW'(THR_ACQ);
    localparam logic signed [AW-1:0] S_MID_X   = $signed({{(AW-S_W){1'b0}}, S_MID});
    localparam logic signed [AW-1:0] S_MAX_X   = $signed({{(AW-S_W){1'b0}}, S_MAX});

    dco_mode_e      state_q, state_d;
    logic [L_W-1:0] l_q, l_d;
    logic [M_W-1:0] m_q, m_d;
    logic [S_W-1:0] s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sat_q, sat_d;
    logic           lock_q, lock_d;

    logic                 dith_en, dith_clr, carry;
    logic signed [AW-1:0] tw_x, ip_x, s_x;

    dco_sd_dither #(.FRAC_W(FRAC_W)) u_dither (
        .clk   (clk),
        .rst   (rst),
        .clr   (dith_clr),
        .en    (dith_en),
        .frac  (tw[FRAC_W-1:0]),
        .carry (carry)
    );

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        m_d      = m_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        dith_en  = 1'b0;
        dith_clr = 1'b0;
        tw_x     = {{2{tw[TW_W-1]}}, tw};
        ip_x     = tw_x >>> FRAC_W;
        s_x      = S_MID_X - ip_x - $signed({{(AW-1){1'b0}}, carry});

        if (!en) begin
            state_d  = MODE_IDLE;
            l_d      = L_MID;
            m_d      = M_MID;
            s_d      = S_MID;
            cnt_d    = '0;
            sat_d    = 1'b0;
            dith_clr = 1'b1;
        end else begin
            case (state_q)
                MODE_IDLE: begin
                    state_d = MODE_PVT;
                    l_d     = L_MID;
                    m_d     = M_MID;
                    s_d     = S_MID;
                end
                MODE_PVT: if (tw_valid) begin
                    // positive tuning word means "too slow": lower code raises frequency
                    if (tw_x > THR_PVT_X) begin
                        cnt_d = '0;
                        sat_d = (l_q == '0);
                        if (l_q != '0) l_d = l_q - 1'b1;
                    end else if (tw_x < -THR_PVT_X) begin
                        cnt_d = '0;
                        sat_d = (l_q == L_MAX);
                        if (l_q != L_MAX) l_d = l_q + 1'b1;
                    end else begin
                        sat_d = 1'b0;
                        if (cnt_q == CW'(LOCK_N - 1)) begin
                            cnt_d   = '0;
                            state_d = MODE_ACQ;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                MODE_ACQ: if (tw_valid) begin
                    if (tw_x > THR_ACQ_X) begin
                        cnt_d = '0;
                        sat_d = (m_q == '0);
                        if (m_q != '0) m_d = m_q - 1'b1;
                    end else if (tw_x < -THR_ACQ_X) begin
                        cnt_d = '0;
                        sat_d = (m_q == M_MAX);
                        if (m_q != M_MAX) m_d = m_q + 1'b1;
                    end else begin
                        sat_d = 1'b0;
                        if (cnt_q == CW'(LOCK_N - 1)) begin
                            cnt_d   = '0;
                            state_d = MODE_TRK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                MODE_TRK: if (tw_valid) begin
                    dith_en = 1'b1;
                    if (s_x < 0) begin
                        s_d   = '0;
                        sat_d = 1'b1;
                    end else if (s_x > S_MAX_X) begin
                        s_d   = S_MAX;
                        sat_d = 1'b1;
                    end else begin
                        s_d   = s_x[S_W-1:0];
                        sat_d = 1'b0;
                    end
                end
                default: state_d = MODE_IDLE;
            endcase
        end
        lock_d = (state_d == MODE_TRK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MODE_IDLE;
            l_q     <= L_MID;
            m_q     <= M_MID;
            s_q     <= S_MID;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            lock_q  <= lock_d;
        end
    end

    assign dco_in_l = l_q;
    assign dco_in_m = m_q;
    assign dco_in_s = s_q;
    assign mode     = state_q;
    assign sat      = sat_q;
    assign lock     = lock_q;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Self-checking bench for dco_tune_ctrl: vector table plus hand-written limit sequences.
module tb_dco_tune_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic signed [15:0] tw = '0;
    logic               tw_valid = 1'b0;
    logic [5:0]         dco_in_l;
    logic [7:0]         dco_in_m;
    logic [5:0]         dco_in_s;
    logic [1:0]         mode;
    logic               sat;
    logic               lock;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dco_tune_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tw       (tw),
        .tw_valid (tw_valid),
        .dco_in_l (dco_in_l),
        .dco_in_m (dco_in_m),
        .dco_in_s (dco_in_s),
        .mode     (mode),
        .sat      (sat),
        .lock     (lock)
    );

    typedef struct {
        string              nm;
        logic               r;
        logic               e;
        logic               v;
        logic signed [15:0] t;
        logic [1:0]         md;
        logic [5:0]         l;
        logic [7:0]         m;
        logic [5:0]         s;
        logic               st;
        logic               lk;
        bit                 chk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(string nm, bit r, bit e, bit v, int t,
                                int md, int l, int m, int s, bit st, bit lk, bit chk);
        vec_t x;
        x.nm = nm; x.r = r; x.e = e; x.v = v; x.t = 16'(t);
        x.md = 2'(md); x.l = 6'(l); x.m = 8'(m); x.s = 6'(s);
        x.st = st; x.lk = lk; x.chk = chk;
        return x;
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst      = v.r;
        en       = v.e;
        tw_valid = v.v;
        tw       = v.t;
        if (v.chk) sb.push_back(v);
        @(posedge clk);
        #1;
        if (v.chk) begin
            e = sb.pop_front();
            total++;
            if ({mode, dco_in_l, dco_in_m, dco_in_s, sat, lock} !==
                {e.md, e.l, e.m, e.s, e.st, e.lk}) begin
                bad++;
                $display("FAIL %s: got mode=%0d l=%0d m=%0d s=%0d sat=%0b lock=%0b want mode=%0d l=%0d m=%0d s=%0d sat=%0b lock=%0b",
                         e.nm, mode, dco_in_l, dco_in_m, dco_in_s, sat, lock,
                         e.md, e.l, e.m, e.s, e.st, e.lk);
            end else begin
                $display("ok %s: mode=%0d l=%0d m=%0d s=%0d sat=%0b lock=%0b",
                         e.nm, mode, dco_in_l, dco_in_m, dco_in_s, sat, lock);
            end
        end
    endtask

    initial begin
        // reset, then coarse search downward from mid-scale
        tbl.push_back(mk("rst",      1, 0, 0, 0, 0, 32, 128, 32, 0, 0, 1));
        tbl.push_back(mk("rst2",     1, 1, 1, 200, 0, 32, 128, 32, 0, 0, 1));
        tbl.push_back(mk("idle2pvt", 0, 1, 0, 0, 1, 32, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk("pvt_dn", 0, 1, 1, 200, 1, 32 - i, 128, 32, 0, 0, 1));
        tbl.push_back(mk("pvt_hold", 0, 1, 0, 0, 1, 27, 128, 32, 0, 0, 1));
        // in-band at exactly +/-THR_PVT
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk("pvt_lock", 0, 1, 1, (i % 2) ? 64 : -64,
                             (i == 8) ? 2 : 1, 27, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk("acq_up", 0, 1, 1, -20, 2, 27, 128 + i, 32, 0, 0, 1));

        // fresh acquisition: an out-of-band sample restarts the lock count
        tbl.push_back(mk("rst",   1, 0, 0, 0, 0, 32, 128, 32, 0, 0, 1));
        tbl.push_back(mk("en",    0, 1, 0, 0, 1, 32, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk("pvt_lock2", 0, 1, 1, 0, (i == 8) ? 2 : 1, 32, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk("acq_in", 0, 1, 1, 0, 2, 32, 128, 32, 0, 0, 1));
        tbl.push_back(mk("acq_out", 0, 1, 1, 9, 2, 32, 127, 32, 0, 0, 1));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk("acq_relock", 0, 1, 1, (i % 2) ? 8 : -8,
                             (i == 8) ? 3 : 2, 32, 127, 32, 0, (i == 8), 1));

        // tracking with dither, then both clip limits
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk("trk_dith", 0, 1, 1, 40, 3, 32, 127, (i % 2) ? 30 : 29, 0, 1, 1));
        tbl.push_back(mk("trk_neg",  0, 1, 1, -40,    3, 32, 127, 35, 0, 1, 1));
        tbl.push_back(mk("trk_hi",   0, 1, 1, 32752,  3, 32, 127, 0,  1, 1, 1));
        tbl.push_back(mk("trk_zero", 0, 1, 1, 0,      3, 32, 127, 32, 0, 1, 1));
        tbl.push_back(mk("trk_lo",   0, 1, 1, -32768, 3, 32, 127, 63, 1, 1, 1));
        tbl.push_back(mk("trk_hold", 0, 1, 0, 0,      3, 32, 127, 63, 1, 1, 1));
        tbl.push_back(mk("en_off",   0, 0, 1, 40,     0, 32, 128, 32, 0, 0, 1));
        tbl.push_back(mk("idle_stay",0, 0, 1, 200,    0, 32, 128, 32, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // large bank driven to zero, then clipped
        step(mk("en", 0, 1, 0, 0, 1, 32, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 32; i++)
            step(mk("pvt_to0", 0, 1, 1, 200, 1, 32 - i, 128, 32, 0, 0, i == 32));
        step(mk("pvt_clip0", 0, 1, 1, 200, 1, 0, 128, 32, 1, 0, 1));
        step(mk("pvt_up1",   0, 1, 1, -200, 1, 1, 128, 32, 0, 0, 1));
        // reset mid-run wins over en/tw_valid and drops the searched code
        step(mk("rst_prio",  1, 1, 1, 200, 0, 32, 128, 32, 0, 0, 1));
        step(mk("en",        0, 1, 0, 0, 1, 32, 128, 32, 0, 0, 1));
        for (int i = 1; i <= 31; i++)
            step(mk("pvt_tomax", 0, 1, 1, -200, 1, 32 + i, 128, 32, 0, 0, i == 31));
        step(mk("pvt_clipmax", 0, 1, 1, -200, 1, 63, 128, 32, 1, 0, 1));
        step(mk("pvt_satkeep", 0, 1, 0, 0, 1, 63, 128, 32, 1, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
